// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: round-robin arbiter sharing one single-port memory between two requesters
module mem_arbiter_2p #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iReqA,
  input  logic                     iWriteA,
  input  logic [ADDRESS_WIDTH-1:0] iAddrA,
  input  logic [DATA_WIDTH-1:0]    iDataA,
  output logic                     oAckA,
  input  logic                     iReqB,
  input  logic                     iWriteB,
  input  logic [ADDRESS_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0]    iDataB,
  output logic                     oAckB,
  output logic [DATA_WIDTH-1:0]    oRData,
  output logic                     oBusy,
  output logic                     oMemCS_n,
  output logic                     oMemRead_n,
  output logic                     oMemWrite_n,
  output logic [ADDRESS_WIDTH-1:0] oMemAddr,
  output logic [DATA_WIDTH-1:0]    oMemWData,
  input  logic [DATA_WIDTH-1:0]    iMemRData
);
  typedef enum logic [1:0] {IDLE, CMD, RDATA, DONE} stateT;
  stateT state, nextState;
  logic lastB, ownerB, isWrite, anyReq, grantB, grantWrite;
  // Pick the winner (the side not served last on a tie) and sequence the transaction
  always_comb begin
    anyReq = iReqA | iReqB;
    grantB = (iReqA & iReqB) ? ~lastB : iReqB;
    grantWrite = grantB ? iWriteB : iWriteA;
    nextState = state;
    case (state)
      IDLE:    nextState = anyReq ? CMD : IDLE;
      CMD:     nextState = isWrite ? DONE : RDATA;
      RDATA:   nextState = DONE;
      default: nextState = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) state <= IDLE;
    else state <= nextState;
  end
  // Registered outputs: strobes for one cycle after grant, read capture, ack on entry to DONE
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      lastB       <= 1'b1;
      ownerB      <= 1'b0;
      isWrite     <= 1'b0;
      oMemCS_n    <= 1'b1;
      oMemRead_n  <= 1'b1;
      oMemWrite_n <= 1'b1;
      oMemAddr    <= '0;
      oMemWData   <= '0;
      oAckA       <= 1'b0;
      oAckB       <= 1'b0;
      oRData      <= '0;
      oBusy       <= 1'b0;
    end else begin
      oMemCS_n    <= 1'b1;
      oMemRead_n  <= 1'b1;
      oMemWrite_n <= 1'b1;
      oAckA       <= 1'b0;
      oAckB       <= 1'b0;
      oBusy       <= (nextState != IDLE);
      if (state == IDLE && anyReq) begin
        lastB       <= grantB;
        ownerB      <= grantB;
        isWrite     <= grantWrite;
        oMemAddr    <= grantB ? iAddrB : iAddrA;
        oMemWData   <= grantB ? iDataB : iDataA;
        oMemCS_n    <= 1'b0;
        oMemWrite_n <= ~grantWrite;
        oMemRead_n  <= grantWrite;
      end
      if (state == RDATA) oRData <= iMemRData;
      if (nextState == DONE) begin
        oAckA <= ~ownerB;
        oAckB <= ownerB;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb_mem_arbiter_2p: directed tests against a transaction-timeline model of the arbiter
module tb_mem_arbiter_2p;
  localparam int DW = 32;
  localparam int AW = 4;

  logic iClk = 1'b0, iReset = 1'b1;
  logic iReqA = 1'b0, iWriteA = 1'b0, iReqB = 1'b0, iWriteB = 1'b0;
  logic [AW-1:0] iAddrA = '0, iAddrB = '0;
  logic [DW-1:0] iDataA = '0, iDataB = '0;
  logic oAckA, oAckB, oBusy, oMemCS_n, oMemRead_n, oMemWrite_n;
  logic [DW-1:0] oRData, oMemWData, iMemRData;
  logic [AW-1:0] oMemAddr;

  mem_arbiter_2p #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .iClk(iClk), .iReset(iReset),
    .iReqA(iReqA), .iWriteA(iWriteA), .iAddrA(iAddrA), .iDataA(iDataA), .oAckA(oAckA),
    .iReqB(iReqB), .iWriteB(iWriteB), .iAddrB(iAddrB), .iDataB(iDataB), .oAckB(oAckB),
    .oRData(oRData), .oBusy(oBusy),
    .oMemCS_n(oMemCS_n), .oMemRead_n(oMemRead_n), .oMemWrite_n(oMemWrite_n),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemRData(iMemRData)
  );

  always #5 iClk = ~iClk;

  // Single-port memory: writes on the strobe edge, read address registered, data follows next cycle
  logic [DW-1:0] tbMem [0:(1<<AW)-1];
  logic [AW-1:0] memRAddr;
  always @(posedge iClk) begin
    if (!oMemCS_n && !oMemWrite_n) tbMem[oMemAddr] <= oMemWData;
    if (!oMemCS_n && !oMemRead_n) memRAddr <= oMemAddr;
  end
  assign iMemRData = tbMem[memRAddr];

  // Model: each grant books a timeline (strobe cycle, ack cycle, free cycle)
  int cyc, freeAt, strobeCyc, ackCyc;
  bit lastB, curB, curW;
  logic [AW-1:0] curAddr;
  logic [DW-1:0] curData, pendR, expRData;
  logic [DW-1:0] modelMem [0:(1<<AW)-1];
  int checks = 0, errors = 0;
  bit ackLog[$];
  bit exp3[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit exp6[3] = '{1'b0, 1'b1, 1'b0};

  task automatic chk(string n, logic [DW-1:0] a, logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic chkb(string n, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask

  task automatic modelReset();
    cyc = 0; freeAt = 0; strobeCyc = -1; ackCyc = -1;
    lastB = 1'b1; curB = 1'b0; curW = 1'b0;
    curAddr = '0; curData = '0; pendR = '0; expRData = '0;
  endtask

  task automatic modelStep();
    bit gB;
    if (iReset) begin
      modelReset();
      return;
    end
    if (cyc >= freeAt && (iReqA || iReqB)) begin
      if (iReqA && iReqB) gB = (lastB == 1'b0);
      else gB = iReqB;
      lastB = gB;
      curB = gB;
      curW = gB ? iWriteB : iWriteA;
      curAddr = gB ? iAddrB : iAddrA;
      curData = gB ? iDataB : iDataA;
      strobeCyc = cyc + 1;
      ackCyc = cyc + (curW ? 2 : 3);
      freeAt = ackCyc + 1;
      if (curW) modelMem[curAddr] = curData;
      else pendR = modelMem[curAddr];
    end
    cyc++;
    if (cyc == ackCyc && !curW) expRData = pendR;
  endtask

  task automatic compareAll();
    bit st;
    st = (cyc == strobeCyc);
    chkb("memCS_n", oMemCS_n, !st);
    chkb("memWrite_n", oMemWrite_n, !(st && curW));
    chkb("memRead_n", oMemRead_n, !(st && !curW));
    chk("memAddr", DW'(oMemAddr), DW'(curAddr));
    chk("memWData", oMemWData, curData);
    chkb("ackA", oAckA, cyc == ackCyc && !curB);
    chkb("ackB", oAckB, cyc == ackCyc && curB);
    chkb("busy", oBusy, cyc < freeAt);
    chk("rData", oRData, expRData);
    if (oAckA) ackLog.push_back(1'b0);
    if (oAckB) ackLog.push_back(1'b1);
  endtask

  task automatic tick();
    @(posedge iClk);
    modelStep();
    @(negedge iClk);
    compareAll();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic setA(logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    iReqA = r; iWriteA = w; iAddrA = a; iDataA = d;
  endtask

  task automatic setB(logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    iReqB = r; iWriteB = w; iAddrB = a; iDataB = d;
  endtask

  task automatic doReset();
    iReset = 1'b1;
    ticks(2);
    iReset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) modelMem[i] = '0;
    modelReset();
    // 1: reset state, then A writes 3 = DEADBEEF
    doReset();
    chkb("t1 reset cs_n", oMemCS_n, 1'b1);
    chkb("t1 reset busy", oBusy, 1'b0);
    chk("t1 reset rData", oRData, 32'h0);
    setA(1, 1, 4'd3, 32'hDEADBEEF);
    tick();
    chkb("t1 cs_n low", oMemCS_n, 1'b0);
    chkb("t1 write_n low", oMemWrite_n, 1'b0);
    chk("t1 addr", DW'(oMemAddr), 32'd3);
    chk("t1 wdata", oMemWData, 32'hDEADBEEF);
    setA(0, 0, 4'd0, 32'h0);
    tick();
    chkb("t1 ackA", oAckA, 1'b1);
    chkb("t1 ackB", oAckB, 1'b0);
    chkb("t1 strobe released", oMemCS_n, 1'b1);
    tick();
    chkb("t1 ackA pulse ends", oAckA, 1'b0);
    // 2: A reads 3
    setA(1, 0, 4'd3, 32'h0);
    tick();
    chkb("t2 read_n low", oMemRead_n, 1'b0);
    chkb("t2 busy c1", oBusy, 1'b1);
    setA(0, 0, 4'd0, 32'h0);
    tick();
    chkb("t2 read_n released", oMemRead_n, 1'b1);
    chkb("t2 busy c2", oBusy, 1'b1);
    tick();
    chkb("t2 ackA", oAckA, 1'b1);
    chk("t2 rData", oRData, 32'hDEADBEEF);
    tick();
    chkb("t2 busy done", oBusy, 1'b0);
    // 3: both hold write requests -> A,B,A,B
    doReset();
    ackLog.delete();
    setA(1, 1, 4'd1, 32'h11111111);
    setB(1, 1, 4'd2, 32'h22222222);
    ticks(11);
    setA(0, 0, 4'd0, 32'h0);
    setB(0, 0, 4'd0, 32'h0);
    tick();
    chk("t3 ack count", 32'(ackLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) chkb($sformatf("t3 ack order %0d", i), ackLog[i], exp3[i]);
    // 4: pointer at A; A reads 5 while B writes 5 -> B first
    setA(1, 1, 4'd7, 32'h77777777);
    tick();
    setA(0, 0, 4'd0, 32'h0);
    ticks(2);
    setA(1, 0, 4'd5, 32'h0);
    setB(1, 1, 4'd5, 32'h12345678);
    tick();
    chkb("t4 B write first", oMemWrite_n, 1'b0);
    setB(0, 0, 4'd0, 32'h0);
    tick();
    chkb("t4 ackB", oAckB, 1'b1);
    ticks(2);
    chkb("t4 A read strobe", oMemRead_n, 1'b0);
    chk("t4 A read addr", DW'(oMemAddr), 32'd5);
    setA(0, 0, 4'd0, 32'h0);
    ticks(2);
    chkb("t4 ackA", oAckA, 1'b1);
    chk("t4 rData", oRData, 32'h12345678);
    tick();
    // 5: reset during RDATA aborts, then a fresh read works
    ackLog.delete();
    setA(1, 0, 4'd2, 32'h0);
    tick();
    setA(0, 0, 4'd0, 32'h0);
    tick();
    iReset = 1'b1;
    #1;
    chkb("t5 async busy", oBusy, 1'b0);
    chkb("t5 async ackA", oAckA, 1'b0);
    chkb("t5 async cs_n", oMemCS_n, 1'b1);
    chk("t5 async rData", oRData, 32'h0);
    chk("t5 async addr", DW'(oMemAddr), 32'h0);
    modelReset();
    ticks(2);
    iReset = 1'b0;
    ticks(2);
    chk("t5 no ack after abort", 32'(ackLog.size()), 32'd0);
    setA(1, 0, 4'd2, 32'h0);
    tick();
    setA(0, 0, 4'd0, 32'h0);
    ticks(2);
    chkb("t5 ackA", oAckA, 1'b1);
    chk("t5 rData", oRData, 32'h22222222);
    tick();
    // 6: A holds request across its ack while B waits -> A,B,A
    ackLog.delete();
    setA(1, 1, 4'd8, 32'h88888888);
    tick();
    setB(1, 1, 4'd9, 32'h99999999);
    ticks(3);
    chkb("t6 B granted", oMemWrite_n, 1'b0);
    chk("t6 B addr", DW'(oMemAddr), 32'd9);
    setB(0, 0, 4'd0, 32'h0);
    ticks(3);
    chk("t6 A re-served addr", DW'(oMemAddr), 32'd8);
    setA(0, 0, 4'd0, 32'h0);
    ticks(3);
    chk("t6 ack count", 32'(ackLog.size()), 32'd3);
    for (int i = 0; i < 3; i++) chkb($sformatf("t6 ack order %0d", i), ackLog[i], exp6[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
